cache_i_param: RTL and testbench
================================

Name: cache_i_param

Overview:
- Parametrised successor L1 instruction cache: 2-way set-associative, read-only, with SETS and words-per-line set at elaboration.
- Sits between the fetch stage and the instruction memory.
- Adds over the prior fixed 4-set/4-word cache:
  - LRU update on fill.
  - Flush/invalidate input.
  - Word-aligned line addressing to memory.
  - Optional hit/miss performance counters.

Parameters:
- ADDR_W, 30, processor word-address width.
- SET_BITS, 2, log2 of set count (SETS = 1<<SET_BITS); range 1..6.
- WORD_BITS, 2, log2 of 32-bit words per line; line width LINE_W = 32<<WORD_BITS.
- TAG_W, ADDR_W-SET_BITS-WORD_BITS, derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- proc_reset  in  1  synchronous, active-high reset.
- proc_read  in  1  fetch request.
- proc_write  in  1  ignored; instruction cache is read-only.
- proc_flush  in  1  one-cycle pulse; invalidate all lines.
- proc_addr  in  ADDR_W  word address.
- proc_wdata  in  32  ignored.
- proc_rdata  out  32  fetched word.
- proc_stall  out  1  miss in progress.
- mem_read  out  1  line read request (registered).
- mem_write  out  1  tied 0.
- mem_addr  out  ADDR_W-WORD_BITS  line address (registered).
- mem_wdata  out  LINE_W  tied 0.
- mem_rdata  in  LINE_W  returned line; word 0 in bits [31:0].
- mem_ready  in  1  one-cycle strobe; mem_rdata valid.
- hit_cnt  out  32  performance counter (see Optional Feature).
- miss_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. proc_reset is synchronous and active-high.
- Reset values:
  - state=IDLE, mem_read=0, mem_addr=0.
  - all valid=0, all lru=0, flush_pend=0, counters=0.
  - tags/data need no reset.
- Address split: tag=proc_addr[ADDR_W-1:SET_BITS+WORD_BITS], set=proc_addr[SET_BITS+WORD_BITS-1:WORD_BITS], off=proc_addr[WORD_BITS-1:0].
- hit_w = valid_w[set] & (tag_w[set]==tag), for w=0,1.
- proc_rdata = selected way's word off; combinational, zero-latency on hit. Value is don't-care when not hit.
- proc_stall = proc_read & ~(hit0|hit1) combinational, also 1 whenever state!=IDLE and proc_read=1.
- lru[set]: 0 means replace way0 next, 1 means replace way1 next.
- FSM states:
  - IDLE:
    - If proc_read & hit: lru[set] <= hit0, i.e. victim becomes the other way.
    - If proc_read & miss: mem_read<=1, mem_addr<=proc_addr[ADDR_W-1:WORD_BITS], go RD. mem_read asserts the cycle after the miss is seen.
  - RD:
    - mem_read held 1 until mem_ready.
    - On mem_ready: mem_read<=0; way v=lru[set] gets valid=1, tag, data=mem_rdata; lru[set]<=~v; go IDLE.
    - Next cycle hits; minimum miss penalty 2 cycles plus memory latency.
- Processor holds proc_addr/proc_read stable while stalled. Behaviour under violation is unspecified; the bench does not exercise it.
- mem_ready in IDLE is ignored.
- Flush:
  - In IDLE: all valid <= 0 next cycle. Overrides a simultaneous hit LRU update. A simultaneous miss still launches.
  - In RD: sets flush_pend. On fill completion the fill is written, then flush_pend clears all valid including the new line, so the request re-misses.
- Reset mid-RD: mem_read drops next cycle; outstanding mem_ready is ignored.

Optional Feature:
- Macro: CACHE_I_PERF_CNT_EN.
- Defined:
  - hit_cnt increments once per IDLE cycle with proc_read & hit.
  - miss_cnt increments once per IDLE→RD transition.
  - Both saturate at 32'hFFFF_FFFF; cleared by reset only.
- Undefined: hit_cnt and miss_cnt tied to 0 and no counter flops. The ports remain.

Decomposition:
- Package cache_i_pkg:
  - state enum {IDLE, RD}.
  - localparams WORD_W=32, NUM_WAYS=2.
  - function for line-word select.
- Sub-module cache_i_way: one way's valid/tag/data arrays, parametrised by SET_BITS/WORD_BITS/TAG_W. It provides a hit compare and word read port and a single fill write port with global invalidate. Instantiated twice.
- Top holds FSM, LRU, flush_pend and counters.

Test Plan:
- Cold miss at default params:
  - Stimulus: reset, read addr 30'h10, memory returns line {32'hD,32'hC,32'hB,32'hA} after 3 cycles.
  - Expect: stall 1 until one cycle after mem_ready; mem_addr=28'h4; rdata=32'hA; subsequent read 30'h11 hits with rdata=32'hB, no stall.
- Conflict and LRU:
  - Stimulus: fill set 0 with tags X and Y, read X, then miss on tag Z.
  - Expect: Z replaces Y; X hits afterwards; Y misses.
- Flush:
  - Stimulus: flush pulse in IDLE after two fills; separately, flush during RD.
  - Expect: in IDLE case, both lines miss next cycle. In RD case, the request re-misses after fill; mem_read re-asserted.
- Reset mid-miss:
  - Stimulus: assert proc_reset while in RD, then pulse mem_ready.
  - Expect: mem_read=0 after reset; no valid lines; next read misses.
- Parametrised instance SET_BITS=3, WORD_BITS=3:
  - Stimulus: miss at addr 30'h1C5.
  - Expect: mem_addr=27'h38; rdata = mem_rdata[191:160].
- With CACHE_I_PERF_CNT_EN:
  - Stimulus: 3 misses, 5 hits.
  - Expect: miss_cnt=3, hit_cnt=5. Without the macro, both read 0.

Source files
------------

// File: rtl/cache_i_pkg.sv
// Shared definitions for the parametrised 2-way instruction cache.
//   - state_e      : controller states (IDLE, RD)
//   - WORD_W       : processor word width (32)
//   - NUM_WAYS     : associativity (2)
//   - line_word()  : pick one 32-bit word out of a cache line
// The line-word helper works on a maximum-width line (64 words) so that
// one function serves every WORD_BITS setting; callers zero-extend.
package cache_i_pkg;

  localparam int WORD_W        = 32;
  localparam int NUM_WAYS      = 2;
  localparam int MAX_WORD_BITS = 6;
  localparam int MAX_LINE_W    = WORD_W << MAX_WORD_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_e;

  // Word 0 lives in bits [31:0]; word k in bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] line_word(
    input logic [MAX_LINE_W-1:0]    line,
    input logic [MAX_WORD_BITS-1:0] off
  );
    logic [MAX_WORD_BITS+4:0] base;
    base = {off, 5'b0};
    return line[base +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_i_way.sv
// One way of the instruction cache: valid bits, tag store and line store.
// Ports:
//   clk, srst          clock, synchronous active-high reset (clears valid)
//   inv_all            clear every valid bit next edge (wins over a fill)
//   rd_set/rd_tag/off  lookup address pieces
//   hit, rd_word       combinational hit flag and addressed word
//   fill_en/set/tag    line write port
//   fill_line          line data written on fill
// Lookups are zero-latency, so the stores are read asynchronously.
module cache_i_way
  import cache_i_pkg::*;
#(
  parameter int SET_BITS  = 2,
  parameter int WORD_BITS = 2,
  parameter int TAG_W     = 26
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          inv_all,
  input  logic [SET_BITS-1:0]           rd_set,
  input  logic [TAG_W-1:0]              rd_tag,
  input  logic [WORD_BITS-1:0]          rd_off,
  output logic                          hit,
  output logic [WORD_W-1:0]             rd_word,
  input  logic                          fill_en,
  input  logic [SET_BITS-1:0]           fill_set,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic [(WORD_W<<WORD_BITS)-1:0] fill_line
);

  localparam int SETS   = 1 << SET_BITS;
  localparam int LINE_W = WORD_W << WORD_BITS;

  logic                  valid_reg [SETS];
  logic [TAG_W-1:0]      tag_mem   [SETS];
  logic [LINE_W-1:0]     data_mem  [SETS];

  logic [MAX_LINE_W-1:0]    line_ext;
  logic [MAX_WORD_BITS-1:0] off_ext;

  // Valid bits are per-set flops: invalidate has priority so that a
  // fill coinciding with a flush leaves the line invalid.
  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (srst || inv_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_en && (fill_set == SET_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_set]  <= fill_tag;
      data_mem[fill_set] <= fill_line;
    end
  end

  assign hit = valid_reg[rd_set] && (tag_mem[rd_set] == rd_tag);

  always_comb begin
    line_ext                = '0;
    line_ext[LINE_W-1:0]    = data_mem[rd_set];
    off_ext                 = '0;
    off_ext[WORD_BITS-1:0]  = rd_off;
  end

  assign rd_word = line_word(line_ext, off_ext);

endmodule

// File: rtl/cache_i_param.sv
// Parametrised 2-way set-associative, read-only L1 instruction cache.
// Sits between fetch and instruction memory; hits return the word in the
// same cycle, misses fetch a whole line and stall the fetch stage.
// Ports:
//   clk, proc_reset       clock, synchronous active-high reset
//   proc_read/proc_addr   fetch request and word address
//   proc_write/proc_wdata accepted but unused (read-only cache)
//   proc_flush            one-cycle pulse, invalidates every line
//   proc_rdata/proc_stall fetched word, miss-in-progress
//   mem_read/mem_addr     registered line request / line address
//   mem_write/mem_wdata   tied to zero
//   mem_rdata/mem_ready   returned line and its one-cycle strobe
//   hit_cnt/miss_cnt      performance counters
// Build option: define CACHE_I_PERF_CNT_EN to implement saturating hit and
// miss counters; without it both counter outputs are constant zero.
module cache_i_param
  import cache_i_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int SET_BITS  = 2,
  parameter int WORD_BITS = 2
) (
  input  logic                             clk,
  input  logic                             proc_reset,
  input  logic                             proc_read,
  input  logic                             proc_write,
  input  logic                             proc_flush,
  input  logic [ADDR_W-1:0]                proc_addr,
  input  logic [31:0]                      proc_wdata,
  output logic [31:0]                      proc_rdata,
  output logic                             proc_stall,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_W-WORD_BITS-1:0]      mem_addr,
  output logic [(32<<WORD_BITS)-1:0]       mem_wdata,
  input  logic [(32<<WORD_BITS)-1:0]       mem_rdata,
  input  logic                             mem_ready,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt
);

  localparam int TAG_W   = ADDR_W - SET_BITS - WORD_BITS;
  localparam int SETS    = 1 << SET_BITS;
  localparam int LINE_AW = ADDR_W - WORD_BITS;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RD   = RD;

  logic [0:0]          state_reg;
  logic                mem_read_reg;
  logic [LINE_AW-1:0]  mem_addr_reg;
  logic [SETS-1:0]     lru_reg;
  logic                flush_pend_reg;

  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_set;
  logic [WORD_BITS-1:0] req_off;
  logic [TAG_W-1:0]     fill_tag;
  logic [SET_BITS-1:0]  fill_set;

  logic [NUM_WAYS-1:0]  hit_w;
  logic [WORD_W-1:0]    word_w [NUM_WAYS];
  logic                 any_hit;
  logic                 miss_launch;
  logic                 fill_go;
  logic                 victim;
  logic                 inv_all;

  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

  assign req_tag = proc_addr[ADDR_W-1:SET_BITS+WORD_BITS];
  assign req_set = proc_addr[SET_BITS+WORD_BITS-1:WORD_BITS];
  assign req_off = proc_addr[WORD_BITS-1:0];

  // The fill target comes from the registered line address rather than
  // the live fetch address, so it is fixed for the whole miss.
  assign fill_tag = mem_addr_reg[LINE_AW-1:SET_BITS];
  assign fill_set = mem_addr_reg[SET_BITS-1:0];

  assign any_hit     = |hit_w;
  assign miss_launch = (state_reg == ST_IDLE) && proc_read && !any_hit;
  assign fill_go     = (state_reg == ST_RD) && mem_ready;
  assign victim      = lru_reg[fill_set];

  // A flush seen during a miss (now or earlier) invalidates on the fill
  // edge itself, so the freshly written line never produces a hit.
  assign inv_all = ((state_reg == ST_IDLE) && proc_flush) ||
                   (fill_go && (flush_pend_reg || proc_flush));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      cache_i_way #(
        .SET_BITS  (SET_BITS),
        .WORD_BITS (WORD_BITS),
        .TAG_W     (TAG_W)
      ) u_way (
        .clk       (clk),
        .srst      (proc_reset),
        .inv_all   (inv_all),
        .rd_set    (req_set),
        .rd_tag    (req_tag),
        .rd_off    (req_off),
        .hit       (hit_w[gi]),
        .rd_word   (word_w[gi]),
        .fill_en   (fill_go && (victim == 1'(gi))),
        .fill_set  (fill_set),
        .fill_tag  (fill_tag),
        .fill_line (mem_rdata)
      );
    end
  endgenerate

  assign proc_rdata = hit_w[1] ? word_w[1] : word_w[0];
  assign proc_stall = proc_read && (!any_hit || (state_reg != ST_IDLE));

  // lru bit names the way to replace next.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg      <= ST_IDLE;
      mem_read_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      lru_reg        <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (proc_read && any_hit && !proc_flush) begin
            lru_reg[req_set] <= hit_w[0];
          end
          if (miss_launch) begin
            mem_read_reg <= 1'b1;
            mem_addr_reg <= proc_addr[ADDR_W-1:WORD_BITS];
            state_reg    <= ST_RD;
          end
        end
        ST_RD: begin
          if (proc_flush) begin
            flush_pend_reg <= 1'b1;
          end
          if (mem_ready) begin
            mem_read_reg      <= 1'b0;
            lru_reg[fill_set] <= ~victim;
            flush_pend_reg    <= 1'b0;
            state_reg         <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

`ifdef CACHE_I_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  logic        hit_event;

  assign hit_event = (state_reg == ST_IDLE) && proc_read && any_hit;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (hit_event && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_launch && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_i_param.sv
// Bench for cache_i_param: a default-parameter instance checked every
// cycle against a recency-list cache model, plus a SET_BITS=3/WORD_BITS=3
// instance checked with literal expectations.
module tb_cache_i_param;

  logic         clk;
  logic         proc_reset;
  logic         proc_read, proc_write, proc_flush;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt, miss_cnt;

  logic         p_read, p_stall, p_mem_read, p_mem_write, p_mem_ready;
  logic [29:0]  p_addr;
  logic [31:0]  p_rdata;
  logic [26:0]  p_mem_addr;
  logic [255:0] p_mem_wdata, p_mem_rdata;
  logic [31:0]  p_hit_cnt_unused, p_miss_cnt_unused;

  int vectors = 0;
  int miscompares = 0;

  logic auto_mem;
  int   inject_req = 0;
  int   inject_done = 0;
  localparam int LAT   = 3;
  localparam int P_LAT = 2;

  cache_i_param dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read),
    .proc_write(proc_write), .proc_flush(proc_flush), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_i_param #(.SET_BITS(3), .WORD_BITS(3)) dut_p (
    .clk(clk), .proc_reset(proc_reset), .proc_read(p_read),
    .proc_write(1'b0), .proc_flush(1'b0), .proc_addr(p_addr),
    .proc_wdata(32'h0), .proc_rdata(p_rdata), .proc_stall(p_stall),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
    .hit_cnt(p_hit_cnt_unused), .miss_cnt(p_miss_cnt_unused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word k of line L. Line 4 holds A,B,C,D.
  function automatic logic [31:0] word_of(input logic [31:0] line, input int k);
    return ((line ^ 32'h4) << 8) + 32'hA + 32'(k);
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] line);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = word_of(line, k);
    return l;
  endfunction

  function automatic logic [255:0] make_line_p(input logic [31:0] line);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = word_of(line, k);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Default-instance memory: auto responds LAT cycles after mem_read,
  // or a single injected strobe on request.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    begin : resp
      int lat;
      lat = 0;
      forever begin
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (inject_req != inject_done) begin
          inject_done = inject_req;
          mem_ready   = 1'b1;
          mem_rdata   = make_line(32'(mem_addr));
        end else if (auto_mem && mem_read) begin
          if (lat == LAT - 1) begin
            mem_ready = 1'b1;
            mem_rdata = make_line(32'(mem_addr));
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  initial begin
    p_mem_ready = 1'b0;
    p_mem_rdata = '0;
    begin : resp_p
      int lat;
      lat = 0;
      forever begin
        @(posedge clk); #1;
        p_mem_ready = 1'b0;
        if (p_mem_read) begin
          if (lat == P_LAT - 1) begin
            p_mem_ready = 1'b1;
            p_mem_rdata = make_line_p(32'(p_mem_addr));
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // Reference model: per set a recency list (index 0 = most recent) of at
  // most two tags, a busy flag with the outstanding line, and a pending
  // flush flag. Checked every negedge, then advanced for the next edge.
  logic [31:0] m_ent [4][2];
  int          m_cnt [4];
  logic        m_busy, m_fp, m_live;
  logic [31:0] m_pend;

  function automatic logic m_has(input int s, input logic [31:0] t);
    return (m_cnt[s] > 0 && m_ent[s][0] == t) || (m_cnt[s] > 1 && m_ent[s][1] == t);
  endfunction

  initial begin
    m_busy = 1'b0; m_fp = 1'b0; m_live = 1'b0; m_pend = '0;
    for (int s = 0; s < 4; s++) m_cnt[s] = 0;
    forever begin
      @(negedge clk);
      begin : cmp
        logic [31:0] a, t, ln;
        int s;
        logic exp_hit, exp_stall;
        a  = 32'(proc_addr);
        s  = int'((a >> 2) & 32'h3);
        t  = a >> 4;
        ln = a >> 2;
        exp_hit   = !m_busy && m_has(s, t);
        exp_stall = proc_read && (m_busy || !exp_hit);
        if (m_live) begin
          check("stall", 32'(proc_stall), 32'(exp_stall));
          check("mem_read", 32'(mem_read), 32'(m_busy));
          if (m_busy) check("mem_addr", 32'(mem_addr), m_pend);
          if (proc_read && !exp_stall)
            check("rdata", proc_rdata, word_of(ln, int'(a & 32'h3)));
        end
        if (proc_reset) begin
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_busy = 1'b0; m_fp = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
          if (!m_busy) begin
            if (proc_flush) begin
              for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (proc_read && exp_hit && m_ent[s][0] != t) begin
              m_ent[s][1] = m_ent[s][0];
              m_ent[s][0] = t;
            end
            if (proc_read && !exp_hit) begin
              m_busy = 1'b1;
              m_pend = ln;
            end
          end else begin
            if (proc_flush) m_fp = 1'b1;
            if (mem_ready) begin
              int fs;
              fs = int'(m_pend & 32'h3);
              m_ent[fs][1] = m_ent[fs][0];
              m_ent[fs][0] = m_pend >> 2;
              if (m_cnt[fs] < 2) m_cnt[fs]++;
              if (m_fp) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
              m_fp = 1'b0;
              m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    proc_reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;
  endtask

  // Issue a fetch and hold it until the cache stops stalling.
  task automatic read_req(input logic [29:0] a, output int stalls, output logic [31:0] data);
    proc_addr = a;
    proc_read = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (proc_stall !== 1'b0 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout: addr %h still stalled after %0d cycles", a, stalls);
    end
    data = proc_rdata;
    $display("read addr=%h stalls=%0d data=%h", a, stalls, data);
    @(posedge clk); #1;
    proc_read = 1'b0;
  endtask

  task automatic pulse_flush();
    proc_flush = 1'b1;
    @(posedge clk); #1;
    proc_flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rises, n;
    logic [31:0] d;
    logic prev;
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_flush = 1'b0;
    proc_addr = '0; proc_wdata = '0; auto_mem = 1'b1;
    p_read = 1'b0; p_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
    check("mem_write_tied", 32'(mem_write), 32'h0);
    check("mem_wdata_tied", 32'(|mem_wdata), 32'h0);
    @(posedge clk); #1;

    // Cold miss at 0x10
    proc_addr = 30'h10; proc_read = 1'b1; st = 0;
    @(negedge clk);
    check("cold_stall_first", 32'(proc_stall), 32'h1);
    check("cold_mem_read_first", 32'(mem_read), 32'h0);
    st = 1;
    @(negedge clk);
    check("cold_mem_read", 32'(mem_read), 32'h1);
    check("cold_mem_addr", 32'(mem_addr), 32'h4);
    while (proc_stall !== 1'b0 && st < 200) begin st++; @(negedge clk); end
    check("cold_stall_cycles", 32'(st), 32'd4);
    check("cold_rdata", proc_rdata, 32'hA);
    $display("read addr=%h stalls=%0d data=%h", 30'h10, st, proc_rdata);
    @(posedge clk); #1;
    proc_read = 1'b0;
    read_req(30'h11, st, d);
    check("next_word_stalls", 32'(st), 32'd0);
    check("next_word_rdata", d, 32'hB);

    // Conflict and LRU in set 0: X=0x100, Y=0x200, Z=0x300
    do_reset();
    read_req(30'h100, st, d);
    read_req(30'h200, st, d);
    read_req(30'h100, st, d);
    check("lru_x_hit", 32'(st), 32'd0);
    read_req(30'h300, st, d);
    check("lru_z_miss", 32'(st), 32'd4);
    read_req(30'h102, st, d);
    check("lru_x_survives", 32'(st), 32'd0);
    read_req(30'h200, st, d);
    check("lru_y_evicted", 32'(st), 32'd4);
    read_req(30'h101, st, d);
    check("lru_x_after_y", 32'(st), 32'd0);

    // Flush in IDLE after two fills
    do_reset();
    read_req(30'h20, st, d);
    read_req(30'h24, st, d);
    read_req(30'h21, st, d);
    check("pre_flush_hit", 32'(st), 32'd0);
    pulse_flush();
    read_req(30'h20, st, d);
    check("flush_line0_miss", 32'(st), 32'd4);
    read_req(30'h24, st, d);
    check("flush_line1_miss", 32'(st), 32'd4);

    // Flush during RD: the request must re-miss after the fill
    do_reset();
    proc_addr = 30'h40; proc_read = 1'b1;
    @(posedge clk); #1;
    pulse_flush();
    rises = 0; n = 0; prev = 1'b1;
    @(negedge clk);
    while (proc_stall !== 1'b0 && n < 200) begin
      if (mem_read === 1'b1 && !prev) rises++;
      prev = mem_read;
      n++;
      @(negedge clk);
    end
    check("flush_rd_reissue", 32'(rises), 32'd1);
    check("flush_rd_rdata", proc_rdata, 32'h140A);
    $display("read addr=%h flush-during-miss reissues=%0d data=%h", 30'h40, rises, proc_rdata);
    @(posedge clk); #1;
    proc_read = 1'b0;

    // Reset while a miss is outstanding
    do_reset();
    auto_mem = 1'b0;
    proc_addr = 30'h50; proc_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midmiss_mem_read", 32'(mem_read), 32'h1);
    proc_read = 1'b0;
    proc_reset = 1'b1;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    check("midmiss_reset_mem_read", 32'(mem_read), 32'h0);
    inject_req++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midmiss_late_ready_ignored", 32'(mem_read), 32'h0);
    auto_mem = 1'b1;
    read_req(30'h50, st, d);
    check("midmiss_rereads_miss", 32'(st), 32'd4);

    // Performance counters: 3 miss fetches (each ends in a hit cycle) + 2 hits
    do_reset();
    read_req(30'h60, st, d);
    read_req(30'h64, st, d);
    read_req(30'h68, st, d);
    read_req(30'h61, st, d);
    read_req(30'h65, st, d);
    @(negedge clk);
`ifdef CACHE_I_PERF_CNT_EN
    check("miss_cnt", miss_cnt, 32'd3);
    check("hit_cnt", hit_cnt, 32'd5);
`else
    check("miss_cnt_off", miss_cnt, 32'd0);
    check("hit_cnt_off", hit_cnt, 32'd0);
`endif
    @(posedge clk); #1;

    // SET_BITS=3, WORD_BITS=3 instance
    p_addr = 30'h1C5; p_read = 1'b1; n = 0;
    @(negedge clk);
    check("p_stall_first", 32'(p_stall), 32'h1);
    @(negedge clk);
    check("p_mem_read", 32'(p_mem_read), 32'h1);
    check("p_mem_addr", 32'(p_mem_addr), 32'h38);
    while (p_stall !== 1'b0 && n < 200) begin n++; @(negedge clk); end
    check("p_rdata_word5", p_rdata, 32'h3C0F);
    $display("param read addr=%h data=%h", 30'h1C5, p_rdata);
    @(posedge clk); #1;
    p_addr = 30'h1C0;
    @(negedge clk);
    check("p_hit_stall", 32'(p_stall), 32'h0);
    check("p_rdata_word0", p_rdata, 32'h3C0A);
    $display("param read addr=%h data=%h", 30'h1C0, p_rdata);
    @(posedge clk); #1;
    p_read = 1'b0;

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
